// File: rtl/kr580_bus_responder.sv
// kr580_bus_responder: KR580VM80A bus slave that turns CPU steps into fixed-latency RAM requests,
// stalls the core via ce, write-protects the monitor ROM and mirrors it at 0000h during boot.
module kr580_bus_responder #(
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] ROM_BASE     = 16'hF800,
  parameter bit          BOOT_SHADOW  = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] address_i,
  input  logic [7:0]  out_i,
  input  logic        we_i,
  output logic [7:0]  in_o,
  output logic        ce_o,
  output logic [15:0] ram_address_o,
  output logic [7:0]  ram_wdata_o,
  output logic        ram_re_o,
  output logic        ram_we_o,
  input  logic [7:0]  ram_rdata_i,
  output logic        boot_o,
  output logic [7:0]  rom_wr_drops_o
);
  typedef enum logic [1:0] {ISSUE, WAIT, DONE} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] in_q, in_d, drops_q, drops_d;
  logic       boot_q, boot_d;
  logic       prot, mirror;
  assign prot          = address_i >= ROM_BASE;
  assign mirror        = boot_q && address_i[15:11] == 5'd0 && !we_i;
  assign ram_address_o = mirror ? {5'b11111, address_i[10:0]} : address_i;
  assign ram_wdata_o   = out_i;
  assign in_o          = in_q;
  assign ce_o          = state_q == DONE;
  assign boot_o        = boot_q;
  assign rom_wr_drops_o = drops_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_d     = in_q;
    drops_d  = drops_q;
    boot_d   = boot_q;
    ram_re_o = 1'b0;
    ram_we_o = 1'b0;
    case (state_q)
      ISSUE: begin
        ram_re_o = !we_i && !reset_i;
        ram_we_o = we_i && !prot && !reset_i;
        drops_d  = (we_i && prot && drops_q != 8'hFF) ? drops_q + 8'd1 : drops_q;
        cnt_d    = 3'(READ_LATENCY - 1);
        state_d  = we_i ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        in_d    = cnt_q == 3'd0 ? ram_rdata_i : in_q;
        state_d = cnt_q == 3'd0 ? DONE : WAIT;
      end
      DONE: begin
        // reaching the monitor ends the boot mirror for good
        boot_d  = boot_q && !prot;
        state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ISSUE;
      cnt_q   <= 3'd0;
      in_q    <= 8'hFF;
      drops_q <= 8'd0;
      boot_q  <= BOOT_SHADOW;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      drops_q <= drops_d;
      boot_q  <= boot_d;
    end
  end
endmodule
